// File: rtl/mult32x32_fast_pkg.sv
// Shared types for the fast 32x32 multiplier: controller state encoding and the
// shift_sel encoding that both the controller and the arithmetic unit agree on.
package mult32x32_fast_pkg;

  typedef enum logic [3:0] {
    IDLE,
    A0B0, A1B0, A2B0, A3B0,
    A0B1, A1B1, A2B1, A3B1
  } mult_state_t;

  // Partial-product shift in bytes: byte index of a plus two bytes per word of b.
  function automatic logic [2:0] shift_of(input logic [1:0] a_sel, input logic b_sel);
    return 3'(a_sel) + 3'({b_sel, 1'b0});
  endfunction

endpackage

// File: rtl/mult32x32_fast_ctrl.sv
// Step sequencer for the fast 32x32 multiplier: walks the 8x16 partial products,
// skipping those whose operand slice is known zero, and pulses done when finished.
module mult32x32_fast_ctrl
  import mult32x32_fast_pkg::*;
#(
  parameter logic SKIP_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       a_msb_is_0,
  input  logic       b_msw_is_0,
  output logic       busy,
  output logic       done,
  output logic [1:0] a_sel,
  output logic       b_sel,
  output logic [2:0] shift_sel,
  output logic       upd_prod,
  output logic       clr_prod
);

  mult_state_t state_q, state_d;
  logic        done_q, done_d;
  logic        skip_a, skip_b;

  assign skip_a = SKIP_EN & a_msb_is_0;
  assign skip_b = SKIP_EN & b_msw_is_0;

  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    upd_prod = 1'b0;
    clr_prod = 1'b0;
    a_sel    = 2'd0;
    b_sel    = 1'b0;
    case (state_q)
      IDLE: begin
        clr_prod = start;
        if (start) state_d = A0B0;
      end
      A0B0: begin a_sel = 2'd0; b_sel = 1'b0; state_d = A1B0; end
      A1B0: begin a_sel = 2'd1; b_sel = 1'b0; state_d = A2B0; end
      A2B0: begin
        a_sel = 2'd2;
        b_sel = 1'b0;
        if (!skip_a)      state_d = A3B0;
        else if (!skip_b) state_d = A0B1;
        else              state_d = IDLE;
      end
      A3B0: begin
        a_sel   = 2'd3;
        b_sel   = 1'b0;
        state_d = skip_b ? IDLE : A0B1;
      end
      A0B1: begin a_sel = 2'd0; b_sel = 1'b1; state_d = A1B1; end
      A1B1: begin a_sel = 2'd1; b_sel = 1'b1; state_d = A2B1; end
      A2B1: begin
        a_sel   = 2'd2;
        b_sel   = 1'b1;
        state_d = skip_a ? IDLE : A3B1;
      end
      A3B1: begin a_sel = 2'd3; b_sel = 1'b1; state_d = IDLE; end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE) begin
      busy     = 1'b1;
      upd_prod = 1'b1;
    end
    shift_sel = shift_of(a_sel, b_sel);
    // The last step's accumulate lands at this edge, so done aligns with a valid product.
    done_d    = busy && (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_mult32x32_fast_ctrl.sv
// Bench for mult32x32_fast_ctrl: two controllers (zero-skip on/off) each driving a
// behavioural product register, checked against plain a*b and the expected step list.
module tb_mult32x32_fast_ctrl;

  logic        clk;
  logic        reset;
  logic        start   [2];
  logic [31:0] a_v     [2];
  logic [31:0] b_v     [2];
  logic        a0_w    [2];
  logic        b0_w    [2];
  logic        busy_w  [2];
  logic        done_w  [2];
  logic [1:0]  asel_w  [2];
  logic        bsel_w  [2];
  logic [2:0]  shift_w [2];
  logic        upd_w   [2];
  logic        clr_w   [2];
  logic [63:0] prod    [2];

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign a0_w[0] = (a_v[0][31:24] == 8'd0);
  assign b0_w[0] = (b_v[0][31:16] == 16'd0);
  assign a0_w[1] = (a_v[1][31:24] == 8'd0);
  assign b0_w[1] = (b_v[1][31:16] == 16'd0);

  mult32x32_fast_ctrl #(.SKIP_EN(1'b1)) u_skip (
    .clk(clk), .reset(reset), .start(start[0]),
    .a_msb_is_0(a0_w[0]), .b_msw_is_0(b0_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .a_sel(asel_w[0]), .b_sel(bsel_w[0]),
    .shift_sel(shift_w[0]), .upd_prod(upd_w[0]), .clr_prod(clr_w[0])
  );

  mult32x32_fast_ctrl #(.SKIP_EN(1'b0)) u_noskip (
    .clk(clk), .reset(reset), .start(start[1]),
    .a_msb_is_0(a0_w[1]), .b_msw_is_0(b0_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .a_sel(asel_w[1]), .b_sel(bsel_w[1]),
    .shift_sel(shift_w[1]), .upd_prod(upd_w[1]), .clr_prod(clr_w[1])
  );

  // Stand-in for the arithmetic unit's product register.
  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) prod[i] <= 64'd0;
      else if (clr_w[i]) prod[i] <= 64'd0;
      else if (upd_w[i])
        prod[i] <= prod[i] +
          ((((64'(a_v[i]) >> (8 * asel_w[i])) & 64'hFF) *
            ((64'(b_v[i]) >> (16 * bsel_w[i])) & 64'hFFFF)) << (8 * shift_w[i]));
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One multiplication on instance inst. Returns in the done cycle (or after a mid-run reset).
  task automatic run_op(input int inst, input logic [31:0] a, input logic [31:0] b,
                        input bit pulse, input int rst_at, input string nm);
    int ea[8];
    int eb[8];
    int ne;
    int steps;
    bit got_done;
    bit sa;
    bit sb;
    sa = (inst == 0) && (a[31:24] == 8'd0);
    sb = (inst == 0) && (b[31:16] == 16'd0);
    ne = 0;
    for (int bb = 0; bb < 2; bb++)
      for (int aa = 0; aa < 4; aa++)
        if (!(sa && aa == 3) && !(sb && bb == 1)) begin
          ea[ne] = aa;
          eb[ne] = bb;
          ne++;
        end
    a_v[inst]   = a;
    b_v[inst]   = b;
    start[inst] = 1'b1;
    #1;
    chk({nm, " clr_on_start"}, 64'(clr_w[inst]), 64'd1);
    tick();
    start[inst] = 1'b0;
    steps    = 0;
    got_done = 1'b0;
    for (int cyc = 0; cyc < 12 && !got_done; cyc++) begin
      if (done_w[inst]) begin
        got_done = 1'b1;
      end else begin
        if (pulse && (steps == 1 || steps == 4)) begin
          start[inst] = 1'b1;
          #1;
          chk({nm, " clr_ignored_busy"}, 64'(clr_w[inst]), 64'd0);
        end
        chk({nm, " busy"}, 64'(busy_w[inst]), 64'd1);
        chk({nm, " upd"}, 64'(upd_w[inst]), 64'd1);
        chk({nm, " done_low"}, 64'(done_w[inst]), 64'd0);
        if (steps < ne) begin
          chk({nm, " a_sel"}, 64'(asel_w[inst]), 64'(ea[steps]));
          chk({nm, " b_sel"}, 64'(bsel_w[inst]), 64'(eb[steps]));
          chk({nm, " shift"}, 64'(shift_w[inst]), 64'(ea[steps] + 8 * eb[steps] / 4));
        end
        if (rst_at == steps) begin
          reset = 1'b1;
          #1;
          chk({nm, " rst_busy"}, 64'(busy_w[inst]), 64'd0);
          chk({nm, " rst_done"}, 64'(done_w[inst]), 64'd0);
          chk({nm, " rst_upd"}, 64'(upd_w[inst]), 64'd0);
          chk({nm, " rst_asel"}, 64'(asel_w[inst]), 64'd0);
          tick();
          reset       = 1'b0;
          start[inst] = 1'b0;
          return;
        end
        steps++;
        tick();
        start[inst] = 1'b0;
      end
    end
    chk({nm, " done_seen"}, 64'(got_done), 64'd1);
    chk({nm, " latency"}, 64'(steps), 64'(ne));
    chk({nm, " product"}, prod[inst], 64'(a) * 64'(b));
    chk({nm, " idle_busy"}, 64'(busy_w[inst]), 64'd0);
  endtask

  task automatic idle_chk(input string nm);
    tick();
    chk({nm, " done_pulse0"}, 64'(done_w[0]), 64'd0);
    chk({nm, " done_pulse1"}, 64'(done_w[1]), 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int inst;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      a_v[i]   = 32'd0;
      b_v[i]   = 32'd0;
    end
    tick();
    tick();
    chk("reset busy", 64'(busy_w[0]), 64'd0);
    chk("reset done", 64'(done_w[0]), 64'd0);
    chk("reset a_sel", 64'(asel_w[0]), 64'd0);
    chk("reset b_sel", 64'(bsel_w[0]), 64'd0);
    chk("reset shift", 64'(shift_w[0]), 64'd0);
    chk("reset upd", 64'(upd_w[0]), 64'd0);
    start[0] = 1'b1;
    #1;
    chk("reset clr_follows_start", 64'(clr_w[0]), 64'd1);
    start[0] = 1'b0;
    #1;
    chk("reset clr_low", 64'(clr_w[0]), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    run_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1, "full");
    chk("full product_const", prod[0], 64'hFFFFFFFE00000001);
    idle_chk("full");
    run_op(0, 32'h00FFFFFF, 32'hFFFFFFFF, 1'b0, -1, "skip_a");
    chk("skip_a product_const", prod[0], 64'h00FFFFFEFF000001);
    idle_chk("skip_a");
    run_op(0, 32'hFFFFFFFF, 32'h0000FFFF, 1'b0, -1, "skip_b");
    chk("skip_b product_const", prod[0], 64'h0000FFFEFFFF0001);
    idle_chk("skip_b");
    run_op(0, 32'd3, 32'd5, 1'b0, -1, "skip_ab");
    chk("skip_ab product_const", prod[0], 64'd15);
    idle_chk("skip_ab");
    run_op(1, 32'd3, 32'd5, 1'b0, -1, "noskip");
    chk("noskip product_const", prod[1], 64'd15);
    idle_chk("noskip");
    run_op(0, 32'h12345678, 32'h9ABCDEF0, 1'b1, -1, "ignored_start");
    idle_chk("ignored_start");
    run_op(0, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, -1, "b2b_first");
    run_op(0, 32'h00000007, 32'hFFFF0009, 1'b0, -1, "b2b_second");
    idle_chk("b2b");
    run_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 3, "mid_reset");
    chk("mid_reset product_cleared", prod[0], 64'd0);
    run_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1, "after_reset");
    idle_chk("after_reset");

    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 1) == 1) ra[31:24] = 8'd0;
      if ($urandom_range(0, 1) == 1) rb[31:16] = 16'd0;
      inst = n % 2;
      run_op(inst, ra, rb, 1'b0, -1, "random");
      if ($urandom_range(0, 3) != 0) idle_chk("random");
    end
    idle_chk("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
